// File: rtl/rvi_fetch_redirect_ctrl_if.sv
// Fetch redirect bus: execute/commit redirect inputs, the fetch request
// handshake toward instruction memory, and the flush/exception outputs.
interface rvi_fetch_redirect_ctrl_if #(
    parameter int CPU_WIDTH = 32,
    parameter int EPOCH_W   = 3
);
    logic                 exVld;
    logic [1:0]           bjEn;
    logic [CPU_WIDTH-1:0] tgtAddr;
    logic                 trapVld;
    logic [CPU_WIDTH-1:0] trapPc;
    logic                 reqVld;
    logic                 reqRdy;
    logic [CPU_WIDTH-1:0] reqAddr;
    logic [EPOCH_W-1:0]   reqEpoch;
    logic                 flush;
    logic                 excpVld;
    logic [CPU_WIDTH-1:0] excpAddr;

    // master: the fetch PC owner
    modport master (
        input  exVld, bjEn, tgtAddr, trapVld, trapPc, reqRdy,
        output reqVld, reqAddr, reqEpoch, flush, excpVld, excpAddr
    );
    modport slave (
        output exVld, bjEn, tgtAddr, trapVld, trapPc, reqRdy,
        input  reqVld, reqAddr, reqEpoch, flush, excpVld, excpAddr
    );
endinterface

// File: rtl/rvi_fetch_redirect_ctrl.sv
// Fetch PC owner: sequential fetch, branch/trap redirects with epoch tagging.
// ZION_RVI_RVC_EN: 2-byte target alignment, no misaligned-target exception.
module rvi_fetch_redirect_ctrl #(
    parameter int                   RV64      = 0,
    parameter int                   CPU_WIDTH = 32 * (RV64 + 1),
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0,
    parameter int                   EPOCH_W   = 3
) (
    input logic clk,
    input logic rst_n,
    rvi_fetch_redirect_ctrl_if.master bus
);
    typedef enum logic [1:0] {RUN, PEND, EXCP} state_e;

    state_e               state_q;
    logic [CPU_WIDTH-1:0] pc_q, pend_pc_q, excp_addr_q;
    logic [EPOCH_W-1:0]   epoch_q, req_epoch_q;
    logic                 req_vld_q, flush_q, excp_vld_q;

    logic                 taken, hs, mis;
    logic [CPU_WIDTH-1:0] tgt;
    logic [EPOCH_W-1:0]   epoch_nxt;

`ifdef ZION_RVI_RVC_EN
    assign tgt = {bus.tgtAddr[CPU_WIDTH-1:1], 1'b0};
    assign mis = 1'b0;
`else
    assign tgt = bus.tgtAddr;
    assign mis = |bus.tgtAddr[1:0];
`endif

    assign taken     = bus.exVld & (|bus.bjEn) & (state_q != EXCP);
    assign hs        = req_vld_q & bus.reqRdy;
    assign epoch_nxt = epoch_q + EPOCH_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            pend_pc_q   <= '0;
            epoch_q     <= '0;
            req_epoch_q <= '0;
            req_vld_q   <= 1'b1;
            flush_q     <= 1'b0;
            excp_vld_q  <= 1'b0;
            excp_addr_q <= '0;
        end else begin
            flush_q <= 1'b0;
            if (bus.trapVld) begin
                // trap wins over everything and drops any stalled request
                state_q     <= RUN;
                pc_q        <= bus.trapPc;
                epoch_q     <= epoch_nxt;
                req_epoch_q <= epoch_nxt;
                req_vld_q   <= 1'b1;
                flush_q     <= 1'b1;
                excp_vld_q  <= 1'b0;
            end else if (taken && mis) begin
                state_q     <= EXCP;
                epoch_q     <= epoch_nxt;
                req_epoch_q <= epoch_nxt;
                req_vld_q   <= 1'b0;
                flush_q     <= 1'b1;
                excp_vld_q  <= 1'b1;
                excp_addr_q <= bus.tgtAddr;
            end else begin
                case (state_q)
                    RUN: begin
                        if (taken) begin
                            epoch_q <= epoch_nxt;
                            flush_q <= 1'b1;
                            if (hs) begin
                                pc_q        <= tgt;
                                req_epoch_q <= epoch_nxt;
                            end else begin
                                // stalled: address/epoch stay frozen until handshake
                                pend_pc_q <= tgt;
                                state_q   <= PEND;
                            end
                        end else if (hs) begin
                            pc_q <= pc_q + CPU_WIDTH'(4);
                        end
                    end
                    PEND: begin
                        if (taken) begin
                            epoch_q   <= epoch_nxt;
                            flush_q   <= 1'b1;
                            pend_pc_q <= tgt;
                        end
                        if (hs) begin
                            pc_q        <= taken ? tgt : pend_pc_q;
                            req_epoch_q <= taken ? epoch_nxt : epoch_q;
                            state_q     <= RUN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.reqVld   = req_vld_q;
    assign bus.reqAddr  = pc_q;
    assign bus.reqEpoch = req_epoch_q;
    assign bus.flush    = flush_q;
    assign bus.excpVld  = excp_vld_q;
    assign bus.excpAddr = excp_addr_q;
endmodule

// File: tb/tb_rvi_fetch_redirect_ctrl.sv
// Directed + randomized bench for rvi_fetch_redirect_ctrl against a reference model.
module tb_rvi_fetch_redirect_ctrl;
    localparam logic [31:0] RPC = 32'h100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rvi_fetch_redirect_ctrl_if #(.CPU_WIDTH(32), .EPOCH_W(3)) bus ();
    rvi_fetch_redirect_ctrl #(.RV64(0), .CPU_WIDTH(32), .RESET_PC(RPC), .EPOCH_W(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model: what the fetch unit should present after each edge
    logic [31:0] m_addr, m_pend_tgt, m_excp_addr;
    logic [2:0]  m_epoch, m_req_epoch;
    bit          m_vld, m_flush, m_excp, m_pend;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_addr = RPC; m_pend_tgt = '0; m_excp_addr = '0;
        m_epoch = '0; m_req_epoch = '0;
        m_vld = 1; m_flush = 0; m_excp = 0; m_pend = 0;
    endtask

    function automatic logic [31:0] eff_tgt(input logic [31:0] t);
`ifdef ZION_RVI_RVC_EN
        return t & ~32'h1;
`else
        return t;
`endif
    endfunction

    function automatic bit misaligned(input logic [31:0] t);
`ifdef ZION_RVI_RVC_EN
        return 1'b0;
`else
        return t[1:0] != 2'b00;
`endif
    endfunction

    // advance the model by one clock edge using the inputs currently driven
    task automatic m_step();
        bit taken, hs;
        m_flush = 0;
        if (bus.trapVld) begin
            m_addr = bus.trapPc; m_epoch++; m_req_epoch = m_epoch;
            m_flush = 1; m_excp = 0; m_pend = 0; m_vld = 1;
        end else if (!m_excp) begin
            taken = bus.exVld && (bus.bjEn != 2'b00);
            hs    = bus.reqRdy;
            if (taken) begin m_epoch++; m_flush = 1; end
            if (taken && misaligned(bus.tgtAddr)) begin
                m_excp = 1; m_excp_addr = bus.tgtAddr; m_vld = 0; m_pend = 0;
                m_req_epoch = m_epoch;
            end else if (m_pend) begin
                if (taken) m_pend_tgt = eff_tgt(bus.tgtAddr);
                if (hs) begin m_addr = m_pend_tgt; m_pend = 0; m_req_epoch = m_epoch; end
            end else if (taken) begin
                if (hs) begin m_addr = eff_tgt(bus.tgtAddr); m_req_epoch = m_epoch; end
                else begin m_pend = 1; m_pend_tgt = eff_tgt(bus.tgtAddr); end
            end else if (hs) begin
                m_addr = m_addr + 32'd4;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".reqVld"}, 64'(bus.reqVld), 64'(m_vld));
        if (m_vld) begin
            chk({tag, ".reqAddr"}, 64'(bus.reqAddr), 64'(m_addr));
            chk({tag, ".reqEpoch"}, 64'(bus.reqEpoch), 64'(m_req_epoch));
        end
        chk({tag, ".flush"}, 64'(bus.flush), 64'(m_flush));
        chk({tag, ".excpVld"}, 64'(bus.excpVld), 64'(m_excp));
        chk({tag, ".excpAddr"}, 64'(bus.excpAddr), 64'(m_excp_addr));
    endtask

    task automatic cycle(input string tag);
        m_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic redirect(input logic [31:0] t, input logic [1:0] bj);
        bus.exVld = 1'b1; bus.bjEn = bj; bus.tgtAddr = t;
    endtask

    initial begin
        logic [2:0] ep0;
        bus.exVld = 0; bus.bjEn = '0; bus.tgtAddr = '0;
        bus.trapVld = 0; bus.trapPc = '0; bus.reqRdy = 1;
        m_reset();
        #12;
        check_all("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("seq0");
        chk("seq0_addr", 64'(bus.reqAddr), 64'h100);
        cycle("seq1");
        chk("seq1_addr", 64'(bus.reqAddr), 64'h104);
        cycle("seq2");
        chk("seq2_addr", 64'(bus.reqAddr), 64'h108);

        redirect(32'h40, 2'b10);
        cycle("redir");
        chk("redir_addr", 64'(bus.reqAddr), 64'h40);
        chk("redir_epoch", 64'(bus.reqEpoch), 64'd1);
        chk("redir_flush", 64'(bus.flush), 64'd1);
        bus.exVld = 0;
        cycle("after_redir");
        chk("flush_one_cycle", 64'(bus.flush), 64'd0);

        bus.reqRdy = 0;
        redirect(32'h80, 2'b01);
        cycle("pend1");
        redirect(32'h90, 2'b11);
        cycle("pend2");
        chk("pend2_flush", 64'(bus.flush), 64'd1);
        bus.exVld = 0;
        cycle("pend_hold");
        chk("pend_hold_addr", 64'(bus.reqAddr), 64'h44);
        chk("pend_hold_epoch", 64'(bus.reqEpoch), 64'd1);
        bus.reqRdy = 1;
        cycle("pend_hs");
        chk("pend_release_addr", 64'(bus.reqAddr), 64'h90);
        chk("pend_release_epoch", 64'(bus.reqEpoch), 64'd3);

`ifndef ZION_RVI_RVC_EN
        redirect(32'h202, 2'b01);
        cycle("misalign");
        chk("excp_addr", 64'(bus.excpAddr), 64'h202);
        chk("excp_vld_drop", 64'(bus.reqVld), 64'd0);
        redirect(32'h300, 2'b10);
        cycle("excp_ignore");
        bus.exVld = 0;
        bus.trapVld = 1; bus.trapPc = 32'h1000;
        cycle("trap");
        chk("trap_addr", 64'(bus.reqAddr), 64'h1000);
        chk("trap_excp_clear", 64'(bus.excpVld), 64'd0);
        bus.trapVld = 0;
`else
        redirect(32'h203, 2'b01);
        cycle("rvc_tgt");
        chk("rvc_addr", 64'(bus.reqAddr), 64'h202);
        chk("rvc_no_excp", 64'(bus.excpVld), 64'd0);
        bus.exVld = 0;
`endif

        ep0 = bus.reqEpoch;
        for (int i = 0; i < 8; i++) begin
            redirect(32'h2000 + 32'(i) * 32'h10, 2'b01);
            cycle("wrap");
        end
        bus.exVld = 0;
        chk("epoch_wrap", 64'(bus.reqEpoch), 64'(ep0));

        for (int i = 0; i < 400; i++) begin
            bus.reqRdy  = ($urandom_range(0, 3) != 0);
            bus.exVld   = ($urandom_range(0, 3) == 0);
            bus.bjEn    = 2'($urandom_range(0, 3));
            bus.tgtAddr = $urandom & ~32'h3;
            if ($urandom_range(0, 7) == 0) bus.tgtAddr[1:0] = 2'($urandom_range(0, 3));
            bus.trapVld = ($urandom_range(0, 31) == 0);
            bus.trapPc  = $urandom;
            cycle("rand");
        end

        bus.exVld = 0; bus.trapVld = 1; bus.trapPc = 32'h500; bus.reqRdy = 1;
        cycle("pre_rst_trap");
        bus.trapVld = 0; bus.reqRdy = 0;
        redirect(32'h600, 2'b01);
        cycle("pre_rst_pend");
        bus.exVld = 0;
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all("async_rst");
        chk("async_rst_addr", 64'(bus.reqAddr), 64'h100);
        @(negedge clk);
        rst_n = 1'b1;
        bus.reqRdy = 1;
        cycle("post_rst");
        chk("post_rst_addr", 64'(bus.reqAddr), 64'h104);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rvi_fetch_redirect_ctrl.md
# rvi_fetch_redirect_ctrl

Fetch-side PC owner and consumer of the branch/jump execute results. It takes the resolved `bjEn`/`tgtAddr` from the execute-stage branch unit and trap redirects from commit, and it maintains the fetch PC. It issues valid/ready fetch requests to instruction memory, and tags each request with a path epoch so stale responses can be dropped. It also raises the pipeline flush and detects misaligned branch targets.

## Interface
- `RV64`, 0: 1 selects a 64-bit datapath.
- `CPU_WIDTH`, 32*(RV64+1): address width.
- `RESET_PC`, 0: PC value loaded at reset.
- `EPOCH_W`, 3: width of the epoch tag.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `exVld`  in  1: the execute-stage branch/jump result is valid this cycle.
- `bjEn`  in  2: `BjEnGen` result; taken when `|bjEn`.
- `tgtAddr`  in  CPU_WIDTH: resolved target from `BjTgtAddr`.
- `trapVld`  in  1: redirect from commit (trap or return).
- `trapPc`  in  CPU_WIDTH: trap redirect PC.
- `reqVld`  out  1: fetch request valid.
- `reqRdy`  in  1: instruction memory accepts the request.
- `reqAddr`  out  CPU_WIDTH: fetch address.
- `reqEpoch`  out  EPOCH_W: path tag carried with the request.
- `flush`  out  1: one-cycle pulse that squashes younger in-flight instructions.
- `excpVld`  out  1: misaligned-target exception, a level signal.
- `excpAddr`  out  CPU_WIDTH: the offending target.

## Operation
- States: RUN, PEND, EXCP.
  - RUN: `reqVld`=1. On handshake (`reqVld & reqRdy`), `pc` advances by 4, wrapping modulo 2^CPU_WIDTH.
  - PEND: a redirect arrived while a request was stalled. `reqVld`=1, and `reqAddr`/`reqEpoch` hold their old values. On handshake, `pc` is set to the saved target and the state returns to RUN.
  - EXCP: `reqVld`=0 and `excpVld`=1. Stays here until `trapVld`.
- A taken redirect is `exVld & |bjEn` with an aligned target.
  - In RUN with no stall (`!reqVld | reqRdy`): `pc`←`tgtAddr`. The state stays RUN.
  - In RUN with a stall (`reqVld & !reqRdy`): `pendPc`←`tgtAddr` and the state goes to PEND. `reqAddr` must never change while a request is stalled.
  - In PEND: `pendPc` is overwritten by the new target (latest wins).
  - In all of these cases, `epoch` increments (wrapping modulo 2^EPOCH_W) and `flush` pulses.
- `exVld` with `bjEn`=0 has no effect.
- Misaligned taken target:
  - The state goes to EXCP and `excpAddr`←`tgtAddr`.
  - `flush` pulses and `epoch` increments.
  - A stalled request is abandoned: `reqVld` drops. This is the only permitted withdrawal.
- `trapVld` has the highest priority and acts from any state.
  - `pc`←`trapPc`, `epoch` increments, `flush` pulses, and the state goes to RUN.
  - `excpVld` clears and `pendPc` is discarded.
  - A stalled request is abandoned in the same way as for a misaligned target.
  - `trapPc` is trusted; no alignment check is applied to it.
- In EXCP, `exVld` is ignored.
- Reset values:
  - State RUN, `pc`=RESET_PC, `epoch`=0.
  - `reqVld`=1 from the first cycle after `rst_n` deasserts.
  - `flush`=0, `excpVld`=0, `excpAddr`=0.
- Reset asserted mid-operation discards all pending state immediately (asynchronous).

## Timing
- All outputs are registered.
- Redirect sampled at edge N:
  - `flush`=1 during cycle N+1, then 0.
  - `reqAddr`=target in cycle N+1 if there was no stall.
  - `reqEpoch` updates in cycle N+1 in all cases, except when the redirect enters PEND: there `reqEpoch` holds its old value until the stalled request's handshake, along with `reqAddr`.
- Handshake and redirect on the same edge: the handshake completes with the old address and epoch, and the next request uses the target. No PEND state is entered.
- Back-to-back redirects on consecutive cycles: each produces its own `flush` pulse and epoch increment.
- Sequential throughput: one request per cycle while `reqRdy`=1.
- Latency from redirect to the new fetch address is 1 cycle without a stall, and 1 cycle after the stalled handshake otherwise.

## Configuration
- `ZION_RVI_RVC_EN` defined:
  - Target alignment is 2 bytes; `tgtAddr[0]` is forced to 0 and no target is ever misaligned.
  - The sequential increment remains 4; the fetch buffer handles 16-bit parcels.
- `ZION_RVI_RVC_EN` undefined: a target is misaligned when `tgtAddr[1:0]`≠0.

## Test plan
- Reset with RESET_PC=0x100 and `reqRdy`=1 for 3 cycles -> `reqAddr` sequence 0x100, 0x104, 0x108; `reqEpoch`=0; `flush`=0.
- At PC 0x108, `exVld`=1, `bjEn`=2'b10, `tgtAddr`=0x40, `reqRdy`=1 -> next cycle `reqAddr`=0x40, `reqEpoch`=1, `flush`=1 for exactly one cycle.
- Hold `reqRdy`=0 at address 0x44, then redirect to 0x80 and then to 0x90 on consecutive cycles -> `reqAddr` stays 0x44 (old epoch) until `reqRdy`=1; the following request is 0x90; the epoch advanced by 2; two `flush` pulses.
- Without `ZION_RVI_RVC_EN`, taken branch to 0x202 -> EXCP, `reqVld`=0, `excpVld`=1, `excpAddr`=0x202. Subsequent `exVld` is ignored. `trapVld` with `trapPc`=0x1000 -> `reqAddr`=0x1000, `excpVld`=0.
- With `ZION_RVI_RVC_EN`, taken to 0x203 -> `reqAddr`=0x202, no exception. With `EPOCH_W`=3, 8 redirects -> epoch wraps from 7 to 0.
- `rst_n` asserted while in PEND -> outputs return to reset values immediately; `pendPc` is never used.
